// File: rtl/micromind_pkg.sv
// Shared constants and types for the micromind RAM arbiter slice.
package micromind_pkg;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Wide enough for MAX_BURST up to 15.
    localparam int BURST_W = 4;

    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/micromind_arb_pick.sv
// Grant selection for the two RAM requesters: round-robin or C-priority with a
// burst guard that forces a D grant after MAX_BURST consecutive C wins.
module micromind_arb_pick
    import micromind_pkg::*;
#(
    parameter int FIXED_PRIO = ARB_RR,
    parameter int MAX_BURST  = 4
) (
    input  logic [1:0]         req,
    input  logic               ptr,
    input  logic [BURST_W-1:0] cnt,
    output logic [1:0]         gnt,
    output logic               ptr_nxt,
    output logic [BURST_W-1:0] cnt_nxt
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        if (FIXED_PRIO == ARB_FIXED) begin
            if (req[PORT_D] && (cnt >= BURST_LIM || !req[PORT_C]))
                gnt[PORT_D] = 1'b1;
            else if (req[PORT_C])
                gnt[PORT_C] = 1'b1;
            // Counts only C wins that D has been waiting through.
            if (!req[PORT_D] || gnt[PORT_D])
                cnt_nxt = '0;
            else if (gnt[PORT_C])
                cnt_nxt = cnt + 1'b1;
        end else begin
            if (req[PORT_C] && (!req[PORT_D] || ptr == PORT_D))
                gnt[PORT_C] = 1'b1;
            else if (req[PORT_D])
                gnt[PORT_D] = 1'b1;
        end
        if (|gnt)
            ptr_nxt = gnt[PORT_D] ? PORT_D : PORT_C;
    end

endmodule

// File: rtl/micromind_mem_arbiter.sv
// Shares the single-port RAM between the micromind core (C) and the debug
// port (D): registered command out, read data routed back two cycles later.
module micromind_mem_arbiter
    import micromind_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = ARB_RR,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]         req;
    logic [1:0]         gnt;
    logic               ptr, ptr_nxt;
    logic [BURST_W-1:0] cnt, cnt_nxt;
    rd_tag_t [2:1]      tag_pipe;
    logic [DATA_W-1:0]  c_rdata_q, d_rdata_q;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    assign req[PORT_C] = c_req;
    assign req[PORT_D] = d_req;

    micromind_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO),
        .MAX_BURST  (MAX_BURST)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .cnt     (cnt),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt),
        .cnt_nxt (cnt_nxt)
    );

    // Registers ignore gnt during reset, so masking the acks keeps both sides consistent.
    assign c_ack = gnt[PORT_C] & ~reset;
    assign d_ack = gnt[PORT_D] & ~reset;

    always_comb begin
        win_we    = c_we;
        win_addr  = c_addr;
        win_wdata = c_wdata;
        if (gnt[PORT_D]) begin
            win_we    = d_we;
            win_addr  = d_addr;
            win_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= PORT_D;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag_pipe  <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            mem_en <= |gnt;
            if (|gnt) begin
                mem_we    <= win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end
            tag_pipe[1].vld  <= (|gnt) & ~win_we;
            tag_pipe[1].port <= gnt[PORT_D];
            tag_pipe[2]      <= tag_pipe[1];
            if (c_rvalid) c_rdata_q <= mem_rdata;
            if (d_rvalid) d_rdata_q <= mem_rdata;
        end
    end

    assign c_rvalid = tag_pipe[2].vld & (tag_pipe[2].port == PORT_C);
    assign d_rvalid = tag_pipe[2].vld & (tag_pipe[2].port == PORT_D);

    // RAM data passes straight through in the return cycle, then is held.
    assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
    assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_micromind_mem_arbiter.sv
// Bench for micromind_mem_arbiter: instance 0 round-robin, instance 1 fixed priority
// (MAX_BURST=4), each attached to its own behavioural RAM.
`timescale 1ns/1ps
module tb_micromind_mem_arbiter;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2];
    logic       c_req[2], c_we[2], d_req[2], d_we[2];
    logic [7:0] c_addr[2], c_wdata[2], d_addr[2], d_wdata[2];
    logic       c_ack[2], c_rvalid[2], d_ack[2], d_rvalid[2];
    logic [7:0] c_rdata[2], d_rdata[2];
    logic       mem_en[2], mem_we[2];
    logic [7:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

    micromind_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0), .MAX_BURST(MAXB)) u_rr (
        .clk(clk), .reset(rst[0]),
        .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
        .c_ack(c_ack[0]), .c_rvalid(c_rvalid[0]), .c_rdata(c_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ack(d_ack[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

    micromind_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1), .MAX_BURST(MAXB)) u_fx (
        .clk(clk), .reset(rst[1]),
        .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
        .c_ack(c_ack[1]), .c_rvalid(c_rvalid[1]), .c_rdata(c_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ack(d_ack[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

    function automatic logic [7:0] init_val(input int a);
        case (a)
            'h10:    init_val = 8'hA5;
            'h11:    init_val = 8'h5B;
            'h12:    init_val = 8'hC3;
            'h20:    init_val = 8'h00;
            'h30:    init_val = 8'hE1;
            'h31:    init_val = 8'h1E;
            default: init_val = 8'(a) ^ 8'h5A;
        endcase
    endfunction

    // Single-port synchronous RAM per instance, read data one cycle after mem_en.
    logic [7:0] ram [2][256];
    logic       ram_init;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_init) begin
                for (int a = 0; a < 256; a++) ram[i][a] <= init_val(a);
                mem_rdata[i] <= 8'h00;
            end else if (mem_en[i]) begin
                if (mem_we[i]) ram[i][mem_addr[i]] <= mem_wdata[i];
                else           mem_rdata[i] <= ram[i][mem_addr[i]];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk8(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %h want %h", name, inst, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int inst, input logic act, input logic exp);
        chk8(name, inst, {7'd0, act}, {7'd0, exp});
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0;
            c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = 8'h00; c_wdata[i] = 8'h00;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 8'h00; d_wdata[i] = 8'h00;
        end
    endtask

    typedef struct {
        int         inst;
        bit         rst;
        bit         creq, cwe;
        logic [7:0] caddr, cwd;
        bit         dreq, dwe;
        logic [7:0] daddr, dwd;
        bit         xcack, xdack, xcrv, xdrv;
        logic [7:0] xcrd, xdrd;
        bit         xen, xwe;
        logic [7:0] xaddr;
    } vec_t;
    vec_t vq[$];

    task automatic add(input int inst, input bit r,
                       input bit cq, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                       input bit dq, input bit dw, input logic [7:0] da, input logic [7:0] dd,
                       input bit xca, input bit xda, input bit xcr, input bit xdr,
                       input logic [7:0] xcd, input logic [7:0] xdd,
                       input bit xen, input bit xwe, input logic [7:0] xad);
        vec_t v;
        v.inst = inst; v.rst = r;
        v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd;
        v.xcack = xca; v.xdack = xda; v.xcrv = xcr; v.xdrv = xdr;
        v.xcrd = xcd; v.xdrd = xdd; v.xen = xen; v.xwe = xwe; v.xaddr = xad;
        vq.push_back(v);
    endtask

    typedef struct {
        int         inst;
        int         cyc;
        bit         port;
        logic [7:0] data;
    } ret_t;
    ret_t rq[$];

    bit         cp[2], dp[2], mlast[2];
    int         mstreak[2];
    logic [7:0] shadow[2][256];
    logic       exp_en[2], exp_we[2];
    logic [7:0] exp_addr[2], exp_wd[2], exp_crd[2], exp_drd[2];

    initial begin : main
        vec_t       v;
        ret_t       e;
        bit         gc, gd, xcr, xdr, act, pk_d, rvv, rv_d, en;
        int         ka, kr;
        logic       we;
        logic [7:0] ad, wd;

        // ---- reset: acks stay low with both requests up; outputs at reset values
        idle_inputs();
        ram_init = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; c_req[i] = 1'b1; d_req[i] = 1'b1; c_addr[i] = 8'h44;
        end
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk1("rst_c_ack", i, c_ack[i], 1'b0);
                chk1("rst_d_ack", i, d_ack[i], 1'b0);
                chk1("rst_mem_en", i, mem_en[i], 1'b0);
                chk1("rst_mem_we", i, mem_we[i], 1'b0);
                chk8("rst_mem_addr", i, mem_addr[i], 8'h00);
                chk8("rst_mem_wdata", i, mem_wdata[i], 8'h00);
                chk1("rst_c_rvalid", i, c_rvalid[i], 1'b0);
                chk1("rst_d_rvalid", i, d_rvalid[i], 1'b0);
            end
        end
        idle_inputs();
        ram_init = 1'b0;

        // ---- directed vectors, round-robin instance
        //   inst rst  c:req we addr  wd   d:req we addr  wd   cack dack crv drv crd    drd    en we addr
        // both requesting from reset: C, D, C, D
        add(0, 0, 1, 0, 'h12, 0, 1, 0, 'h11, 0, 1, 0, 0, 0, 'h00, 'h00, 0, 0, 'h00);
        add(0, 0, 1, 0, 'h12, 0, 1, 0, 'h11, 0, 0, 1, 0, 0, 'h00, 'h00, 1, 0, 'h12);
        add(0, 0, 1, 0, 'h12, 0, 1, 0, 'h11, 0, 1, 0, 1, 0, 'hC3, 'h00, 1, 0, 'h11);
        add(0, 0, 1, 0, 'h12, 0, 1, 0, 'h11, 0, 0, 1, 0, 1, 'hC3, 'h5B, 1, 0, 'h12);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 1, 0, 'hC3, 'h5B, 1, 0, 'h11);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 'hC3, 'h5B, 0, 0, 'h11);
        // core-only read of 0x10
        add(0, 0, 1, 0, 'h10, 0, 0, 0, 'h00, 0, 1, 0, 0, 0, 'hC3, 'h5B, 0, 0, 'h11);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 'hC3, 'h5B, 1, 0, 'h10);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 1, 0, 'hA5, 'h5B, 0, 0, 'h10);
        // debug write 0x3C -> 0x20, core reads 0x20 next cycle
        add(0, 0, 0, 0, 'h00, 0, 1, 1, 'h20, 'h3C, 0, 1, 0, 0, 'hA5, 'h5B, 0, 0, 'h10);
        add(0, 0, 1, 0, 'h20, 0, 0, 0, 'h00, 0, 1, 0, 0, 0, 'hA5, 'h5B, 1, 1, 'h20);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 'hA5, 'h5B, 1, 0, 'h20);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 1, 0, 'h3C, 'h5B, 0, 0, 'h20);
        // read granted, then reset: the read never returns, first tie goes to C
        add(0, 0, 1, 0, 'h12, 0, 0, 0, 'h00, 0, 1, 0, 0, 0, 'h3C, 'h5B, 0, 0, 'h20);
        add(0, 1, 1, 0, 'h10, 0, 1, 0, 'h11, 0, 0, 0, 0, 0, 'h3C, 'h5B, 1, 0, 'h12);
        add(0, 0, 1, 0, 'h10, 0, 1, 0, 'h11, 0, 1, 0, 0, 0, 'h00, 'h00, 0, 0, 'h00);
        add(0, 0, 0, 0, 'h00, 0, 1, 0, 'h11, 0, 0, 1, 0, 0, 'h00, 'h00, 1, 0, 'h10);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 1, 0, 'hA5, 'h00, 1, 0, 'h11);
        add(0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 'hA5, 'h5B, 0, 0, 'h11);
        // fixed priority, both held 10 cycles: C C C C D C C C C D, then drain
        for (int k = 0; k < 12; k++) begin
            act  = (k < 10);
            pk_d = (k % 5 == 4);
            ka   = (k - 1 > 9) ? 9 : k - 1;
            kr   = k - 2;
            en   = (k >= 1) && (k <= 10);
            rvv  = (kr >= 0) && (kr <= 9);
            rv_d = rvv && (kr % 5 == 4);
            add(1, 0, act, 0, 'h30, 0, act, 0, 'h31, 0,
                act && !pk_d, act && pk_d, rvv && !rv_d, rv_d,
                (k >= 2) ? 8'hE1 : 8'h00, (k >= 6) ? 8'h1E : 8'h00,
                en, 0, (k == 0) ? 8'h00 : ((ka % 5 == 4) ? 8'h31 : 8'h30));
        end

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            @(posedge clk); #1;
            idle_inputs();
            rst[v.inst]     = v.rst;
            c_req[v.inst]   = v.creq;  c_we[v.inst]    = v.cwe;
            c_addr[v.inst]  = v.caddr; c_wdata[v.inst] = v.cwd;
            d_req[v.inst]   = v.dreq;  d_we[v.inst]    = v.dwe;
            d_addr[v.inst]  = v.daddr; d_wdata[v.inst] = v.dwd;
            @(negedge clk);
            chk1("vec_c_ack", v.inst, c_ack[v.inst], v.xcack);
            chk1("vec_d_ack", v.inst, d_ack[v.inst], v.xdack);
            chk1("vec_c_rvalid", v.inst, c_rvalid[v.inst], v.xcrv);
            chk1("vec_d_rvalid", v.inst, d_rvalid[v.inst], v.xdrv);
            chk8("vec_c_rdata", v.inst, c_rdata[v.inst], v.xcrd);
            chk8("vec_d_rdata", v.inst, d_rdata[v.inst], v.xdrd);
            chk1("vec_mem_en", v.inst, mem_en[v.inst], v.xen);
            chk1("vec_mem_we", v.inst, mem_we[v.inst], v.xwe);
            chk8("vec_mem_addr", v.inst, mem_addr[v.inst], v.xaddr);
        end

        // ---- randomized traffic against the reference model
        @(posedge clk); #1;
        idle_inputs();
        rst[0] = 1'b1; rst[1] = 1'b1; ram_init = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0; ram_init = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cp[i] = 0; dp[i] = 0; mlast[i] = 1'b1; mstreak[i] = 0;
            exp_en[i] = 0; exp_we[i] = 0; exp_addr[i] = 0; exp_wd[i] = 0;
            exp_crd[i] = 0; exp_drd[i] = 0;
            for (int a = 0; a < 256; a++) shadow[i][a] = init_val(a);
        end
        rq.delete();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!cp[i] && $urandom_range(3) != 0) begin
                    cp[i] = 1;
                    c_we[i] = 1'($urandom_range(1));
                    c_addr[i] = 8'($urandom_range(15));
                    c_wdata[i] = 8'($urandom);
                end
                if (!dp[i] && $urandom_range(3) != 0) begin
                    dp[i] = 1;
                    d_we[i] = 1'($urandom_range(1));
                    d_addr[i] = 8'($urandom_range(15));
                    d_wdata[i] = 8'($urandom);
                end
                c_req[i] = cp[i];
                d_req[i] = dp[i];
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                gc = 0; gd = 0;
                if (i == 1) begin
                    // C first, unless D has watched MAX_BURST C wins go by
                    if (d_req[i] && (mstreak[i] >= MAXB || !c_req[i])) gd = 1;
                    else if (c_req[i]) gc = 1;
                end else if (c_req[i] && d_req[i]) begin
                    gc = mlast[i];
                    gd = !mlast[i];
                end else begin
                    gc = c_req[i];
                    gd = d_req[i];
                end
                chk1("rnd_c_ack", i, c_ack[i], gc);
                chk1("rnd_d_ack", i, d_ack[i], gd);
                chk1("rnd_mem_en", i, mem_en[i], exp_en[i]);
                chk1("rnd_mem_we", i, mem_we[i], exp_we[i]);
                chk8("rnd_mem_addr", i, mem_addr[i], exp_addr[i]);
                chk8("rnd_mem_wdata", i, mem_wdata[i], exp_wd[i]);
                xcr = 0; xdr = 0;
                for (int q = 0; q < rq.size(); q++) begin
                    if (rq[q].inst == i && rq[q].cyc == n) begin
                        if (rq[q].port) begin xdr = 1; exp_drd[i] = rq[q].data; end
                        else            begin xcr = 1; exp_crd[i] = rq[q].data; end
                    end
                end
                chk1("rnd_c_rvalid", i, c_rvalid[i], xcr);
                chk1("rnd_d_rvalid", i, d_rvalid[i], xdr);
                chk8("rnd_c_rdata", i, c_rdata[i], exp_crd[i]);
                chk8("rnd_d_rdata", i, d_rdata[i], exp_drd[i]);

                exp_en[i] = gc | gd;
                if (gc | gd) begin
                    we = gd ? d_we[i]    : c_we[i];
                    ad = gd ? d_addr[i]  : c_addr[i];
                    wd = gd ? d_wdata[i] : c_wdata[i];
                    exp_we[i] = we; exp_addr[i] = ad; exp_wd[i] = wd;
                    if (we) shadow[i][ad] = wd;
                    else begin
                        e.inst = i; e.cyc = n + 2; e.port = gd; e.data = shadow[i][ad];
                        rq.push_back(e);
                    end
                    mlast[i] = gd;
                end
                if (!d_req[i] || gd) mstreak[i] = 0;
                else if (gc)         mstreak[i] = mstreak[i] + 1;
                if (gc) cp[i] = 0;
                if (gd) dp[i] = 0;
            end
            while (rq.size() > 0 && rq[0].cyc <= n) void'(rq.pop_front());
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
